// File: rtl/rename_if.sv
// Rename request/response bundle between the issue stage and the rename block.
interface rename_if;
   logic       issue_valid;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       retire_valid;
   logic [5:0] retire_phys_reg;
   logic [5:0] phys_rd;
   logic [5:0] phys_rs1;
   logic [5:0] phys_rs2;
   logic       free_list_empty;

   modport master (
      output issue_valid, rd, rs1, rs2, retire_valid, retire_phys_reg,
      input  phys_rd, phys_rs1, phys_rs2, free_list_empty
   );

   modport slave (
      input  issue_valid, rd, rs1, rs2, retire_valid, retire_phys_reg,
      output phys_rd, phys_rs1, phys_rs2, free_list_empty
   );
endinterface

// File: rtl/rename.sv
// Register rename: 32-entry RAT plus a 64-deep circular free list of
// physical registers. reset_n is active-high despite its name.
module rename (
   input logic     clk,
   input logic     reset_n,
   rename_if.slave bus
);
   logic [5:0] r_rat [32];
   logic [5:0] r_fl  [64];
   logic [5:0] r_head;
   logic [5:0] r_tail;
   logic [6:0] r_count;
   logic [5:0] r_phys_rd;
   logic [5:0] r_phys_rs1;
   logic [5:0] r_phys_rs2;

   logic       w_alloc;
   logic       w_free;

   // Allocation only draws on entries already in the list before this edge,
   // so a retire in the same cycle cannot rescue an issue while empty.
   assign w_alloc = bus.issue_valid && (bus.rd != '0) && (r_count != '0);
   assign w_free  = bus.retire_valid && (bus.retire_phys_reg != '0) && (r_count != 7'd64);

   assign bus.phys_rd         = r_phys_rd;
   assign bus.phys_rs1        = r_phys_rs1;
   assign bus.phys_rs2        = r_phys_rs2;
   assign bus.free_list_empty = (r_count == '0);

   // Registered rename results; sources read the RAT before this edge's update.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_phys_rd  <= '0;
         r_phys_rs1 <= '0;
         r_phys_rs2 <= '0;
      end else if (bus.issue_valid) begin
         r_phys_rs1 <= r_rat[bus.rs1];
         r_phys_rs2 <= r_rat[bus.rs2];
         r_phys_rd  <= w_alloc ? r_fl[r_head] : '0;
      end
   end

   // RAT: identity mapping out of reset, rd remapped to the allocated head entry.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         for (int unsigned i = 0; i < 32; i++) begin
            r_rat[i] <= 6'(i);
         end
      end else if (w_alloc) begin
         r_rat[bus.rd] <= r_fl[r_head];
      end
   end

   // Free-list storage: physical registers 32..63 are free out of reset.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         for (int unsigned i = 0; i < 64; i++) begin
            r_fl[i] <= (i < 32) ? 6'(i + 32) : '0;
         end
      end else if (w_free) begin
         r_fl[r_tail] <= bus.retire_phys_reg;
      end
   end

   // Free-list pointers and occupancy; net count change covers issue and retire together.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_head  <= '0;
         r_tail  <= 6'd32;
         r_count <= 7'd32;
      end else begin
         if (w_alloc) begin
            r_head <= r_head + 6'd1;
         end
         if (w_free) begin
            r_tail <= r_tail + 6'd1;
         end
         r_count <= r_count + {6'd0, w_free} - {6'd0, w_alloc};
      end
   end
endmodule

// File: tb/tb_rename.sv
// Scoreboard bench for the rename block against a queue-based reference model.
module tb_rename;
   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   rename_if bus ();

   rename dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int    prd;
      int    prs1;
      int    prs2;
      int    empty;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: RAT as an int array, free list as a plain FIFO queue.
   int   m_rat[32];
   int   m_fl[$];
   int   m_prd, m_prs1, m_prs2;

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_rat[i] = i;
      m_fl.delete();
      for (int i = 32; i < 64; i++) m_fl.push_back(i);
      m_prd  = 0;
      m_prs1 = 0;
      m_prs2 = 0;
   endfunction

   function automatic void cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // One cycle of stimulus; the model is advanced and the expectation queued.
   task automatic step(input bit iv, input int rd, input int rs1, input int rs2,
                       input bit rv, input int rr, input string tag);
      int n0, s1, s2;
      @(posedge clk);
      #1;
      bus.issue_valid     = iv;
      bus.rd              = 5'(rd);
      bus.rs1             = 5'(rs1);
      bus.rs2             = 5'(rs2);
      bus.retire_valid    = rv;
      bus.retire_phys_reg = 6'(rr);
      n0 = m_fl.size();
      if (iv) begin
         s1 = m_rat[rs1];
         s2 = m_rat[rs2];
         if (rd != 0 && n0 > 0) begin
            m_prd = m_fl.pop_front();
            m_rat[rd] = m_prd;
         end else begin
            m_prd = 0;
         end
         m_prs1 = s1;
         m_prs2 = s2;
      end
      if (rv && rr != 0 && n0 < 64) m_fl.push_back(rr);
      if (iv || rv) sb.push_back('{m_prd, m_prs1, m_prs2, (m_fl.size() == 0) ? 1 : 0, tag});
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.issue_valid  = 1'b0;
      bus.retire_valid = 1'b0;
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock.
   task automatic apply_reset(input string tag);
      @(negedge clk);
      #2;
      bus.issue_valid  = 1'b0;
      bus.retire_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      cmp({tag, "_rd"},    int'(bus.phys_rd), 0);
      cmp({tag, "_rs1"},   int'(bus.phys_rs1), 0);
      cmp({tag, "_rs2"},   int'(bus.phys_rs2), 0);
      cmp({tag, "_empty"}, int'(bus.free_list_empty), 0);
      sb.delete();
      model_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
   endtask

   // Monitor: one expectation per cycle in which issue or retire was presented.
   logic active_q;
   always @(posedge clk or posedge reset_n) begin
      if (reset_n) active_q <= 1'b0;
      else         active_q <= bus.issue_valid || bus.retire_valid;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset_n && active_q) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: output cycle with no expectation at %0t", $time);
         end else begin
            e = sb.pop_front();
            cmp({e.tag, "_rd"},    int'(bus.phys_rd), e.prd);
            cmp({e.tag, "_rs1"},   int'(bus.phys_rs1), e.prs1);
            cmp({e.tag, "_rs2"},   int'(bus.phys_rs2), e.prs2);
            cmp({e.tag, "_empty"}, int'(bus.free_list_empty), e.empty);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cnt;
      reset_n              = 1'b1;
      bus.issue_valid      = 1'b0;
      bus.retire_valid     = 1'b0;
      bus.rd               = '0;
      bus.rs1              = '0;
      bus.rs2              = '0;
      bus.retire_phys_reg  = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      cmp("reset_rd",    int'(bus.phys_rd), 0);
      cmp("reset_rs1",   int'(bus.phys_rs1), 0);
      cmp("reset_rs2",   int'(bus.phys_rs2), 0);
      cmp("reset_empty", int'(bus.free_list_empty), 0);
      @(negedge clk);
      reset_n = 1'b0;

      // Back-to-back issues with dependent sources.
      step(1, 1, 2, 3, 0, 0, "b2b1");
      step(1, 2, 4, 1, 0, 0, "b2b2");
      step(1, 3, 5, 2, 0, 0, "b2b3");
      step(0, 0, 0, 0, 0, 0, "hold");
      step(1, 0, 1, 2, 0, 0, "rd0");
      step(1, 7, 7, 7, 0, 0, "self_src");
      idle();

      // Retire then issue; the retired entry lands at index 32 and comes out after 63.
      apply_reset("rst1");
      step(0, 0, 0, 0, 1, 2, "ret2");
      step(1, 4, 3, 1, 0, 0, "ret_iss");
      for (int i = 0; i < 32; i++) step(1, 1 + (i % 31), i % 32, (i * 7) % 32, 0, 0, "drain");
      step(1, 5, 1, 2, 0, 0, "after_empty");
      idle();

      // Exhaustion, then recovery by a single retire.
      apply_reset("rst2");
      for (int i = 0; i < 32; i++) step(1, 1 + (i % 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, "exh");
      step(1, 6, 6, 1, 0, 0, "exh33");
      step(0, 0, 0, 0, 1, 0, "ret0");
      step(1, 4, 4, 5, 1, 9, "empty_iss_ret");
      step(0, 0, 0, 0, 1, 3, "ret3");
      step(1, 8, 9, 10, 0, 0, "recover");
      idle();

      // Fill to 64; a further retire is dropped.
      apply_reset("rst3");
      for (int i = 1; i <= 32; i++) step(0, 0, 0, 0, 1, i, "fill");
      step(0, 0, 0, 0, 1, 50, "full_drop");
      step(1, 9, 9, 9, 1, 51, "full_iss_ret");
      for (int i = 0; i < 66; i++) step(1, 1 + (i % 31), $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, "full_drain");
      idle();

      // Randomised traffic with one reset asserted mid-stream.
      apply_reset("rst4");
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            idle();
            apply_reset("rst_mid");
         end
         step($urandom_range(0, 3) != 0,
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
              $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 2) == 0,
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 63),
              "rand");
      end
      idle();

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
      end
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rename.md
RENAME -- requirements
Module: rename

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and reset_n (the reset port keeps the codebase name reset_n, but it is active-high).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-high reset.
REQ-004 rd  input  5  architectural destination register of the issuing instruction.
REQ-005 rs1  input  5  architectural source register 1.
REQ-006 rs2  input  5  architectural source register 2.
REQ-007 issue_valid  input  1  rename request, sampled at the rising edge of clk.
REQ-008 retire_valid  input  1  return retire_phys_reg to the free list, sampled at the rising edge of clk.
REQ-009 retire_phys_reg  input  6  physical register being freed.
REQ-010 phys_rd  output  6  physical register allocated for rd; registered.
REQ-011 phys_rs1  output  6  physical mapping of rs1; registered.
REQ-012 phys_rs2  output  6  physical mapping of rs2; registered.
REQ-013 free_list_empty  output  1  high when the free list count is 0; combinational from the count.

Function
REQ-014 Storage SHALL be:
- a register alias table (RAT) of 32 entries x 6 bits;
- a circular free-list FIFO of 64 entries x 6 bits, with a 6-bit head pointer, a 6-bit tail pointer and a 7-bit count (0..64);
- both pointers wrap modulo 64.
REQ-015 Issue SHALL occur when issue_valid=1 at a rising clk edge. On that edge:
- phys_rs1 <= RAT[rs1] and phys_rs2 <= RAT[rs2], read before any RAT update in the same cycle.
REQ-016 If an issue has rd!=0 and count>0, on that edge:
- phys_rd <= free-list head entry;
- RAT[rd] <= that head entry;
- head increments and count decrements.
REQ-017 If an issue has rd==0:
- phys_rd <= 0;
- no allocation occurs and RAT[0] stays 0.
REQ-018 If an issue has rd!=0 and count==0:
- phys_rd <= 0;
- the RAT and the free list are unchanged;
- the source outputs still update per REQ-015.
REQ-019 When retire_valid=1 at a rising edge:
- if count<64 and retire_phys_reg!=0, retire_phys_reg is written at the tail, the tail increments and count increments;
- otherwise the retire is dropped.
REQ-020 Simultaneous issue and retire in one cycle SHALL both take effect, with the net count change computed from both. An allocation SHALL use only entries present before the edge: there is no retire-to-issue bypass, so an issue while empty still fails.
REQ-021 A source equal to rd in the same instruction SHALL return the old mapping.
REQ-022 When no issue occurs, all three phys_* outputs SHALL hold their values.
REQ-023 Latency SHALL be: outputs valid one clock after the issue edge, with RAT updates visible to the next issue.

Reset
REQ-024 When reset_n=1 (asynchronous, overriding all other activity), the block SHALL reset to:
- RAT[i]=i for i=0..31;
- free-list entries 0..31 holding physical registers 32..63 in order;
- head=0, tail=32, count=32;
- phys_rd, phys_rs1 and phys_rs2 all 0;
- free_list_empty=0.
REQ-025 Asserting reset mid-sequence SHALL discard all in-flight mappings and allocations.

Verification
REQ-026 Back-to-back issues after reset:
- (rd1,rs2,rs3) -> phys_rd=32, phys_rs1=2, phys_rs2=3;
- (rd2,rs4,rs1) -> 33, 4, 32;
- (rd3,rs5,rs2) -> 34, 5, 33.
REQ-027 Retire then issue after reset:
- retire 2, then issue (rd4,rs3,rs1) -> phys_rd=32, phys_rs1=3, phys_rs2=1;
- count is 32 after the issue;
- the entry 2 sits at index 32 and is allocated after 63.
REQ-028 Exhaustion: 32 issues with rd!=0 after reset -> free_list_empty=1. A 33rd issue -> phys_rd=0 with the RAT unchanged.
REQ-029 Recovery from empty: retire 3 -> free_list_empty=0, then issue (rd8,rs9,rs10) -> phys_rd=3, and the source values equal the current RAT[9] and RAT[10].
REQ-030 Edge cases:
- an issue with rd=0 -> phys_rd=0 and count unchanged;
- retire 0 -> ignored;
- reset asserted mid-sequence -> all state returns to the REQ-024 values immediately, without waiting for a clock edge.
